// File: rtl/i2c_eeprom_seq.sv
// Sequencer that runs one random-access EEPROM byte write or byte read per command
// over the I2C register-interface CPU bus. Optional watchdog: define I2C_SEQ_TIMEOUT_EN.
module i2c_eeprom_seq #(
   parameter int unsigned ADDR_BYTES     = 2,
   parameter logic        SACK_OK        = 1'b0,
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_rd,
   input  logic [6:0]  cmd_dev,
   input  logic [15:0] cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_nack,
   output logic        rsp_timeout,
   output logic        busy,
   output logic        ri_a,
   output logic        ri_ce,
   output logic        ri_wren,
   output logic        ri_ren,
   output logic [7:0]  ri_from_cpu,
   input  logic [7:0]  ri_to_cpu,
   input  logic        ri_int
);

   typedef enum logic [3:0] {
      IDLE, ISSUE_D, ISSUE_S, WAIT_RDY, STAT_RD, STAT_WAIT, DATA_RD, DATA_WAIT, DONE
   } state_t;

   localparam logic [7:0] CMD_START     = 8'h01;
   localparam logic [7:0] CMD_STOP      = 8'h02;
   localparam logic [7:0] CMD_WRITE     = 8'h08;
   localparam logic [7:0] CMD_READ_NACK = 8'h14;

   if (ADDR_BYTES < 1 || ADDR_BYTES > 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535)
   begin : g_bad_config
      $error("i2c_eeprom_seq: ADDR_BYTES must be 1..2 and TIMEOUT_CYCLES 1..65535");
   end

   state_t      state, state_nx;
   logic [2:0]  step;
   logic [2:0]  step_next;
   logic        wait_cnt;
   logic        nack_stop;
   logic        accept;

   logic        rd_q;
   logic [6:0]  dev_q;
   logic [15:0] addr_q;
   logic [7:0]  wdata_q;

   logic [7:0]  step_byte;
   logic [7:0]  step_cmd;
   logic        step_check_ack;
   logic        step_data_rd;
   logic        step_last;
   logic        ack_bad;
   logic        wd_expire;
   logic        tmo_q;

   // Steps that put a byte on the data register before their status command.
   function automatic logic has_byte(input logic [2:0] s, input logic rd);
      return (s >= 3'd1 && s <= 3'd3) || (s == 3'd4 && !rd) || (s == 3'd5 && rd);
   endfunction

   assign accept    = (state == IDLE) && cmd_valid;
   assign step_next = (step == 3'd1 && ADDR_BYTES == 1) ? 3'd3 : step + 3'd1;

   // Sequence table: write 0..5 = START,dev,ahi,alo,data,STOP; read 0..7 adds START,dev|1,READ.
   always_comb begin
      step_byte      = 8'h00;
      step_cmd       = CMD_WRITE;
      step_check_ack = 1'b0;
      step_data_rd   = 1'b0;
      step_last      = 1'b0;
      case (step)
         3'd0: step_cmd = CMD_START;
         3'd1: begin step_byte = {dev_q, 1'b0}; step_check_ack = 1'b1; end
         3'd2: begin step_byte = addr_q[15:8];  step_check_ack = 1'b1; end
         3'd3: begin step_byte = addr_q[7:0];   step_check_ack = 1'b1; end
         3'd4: begin
            if (rd_q) begin
               step_cmd = CMD_START;
            end else begin
               step_byte      = wdata_q;
               step_check_ack = 1'b1;
            end
         end
         3'd5: begin
            if (rd_q) begin
               step_byte      = {dev_q, 1'b1};
               step_check_ack = 1'b1;
            end else begin
               step_cmd  = CMD_STOP;
               step_last = 1'b1;
            end
         end
         3'd6: begin step_cmd = CMD_READ_NACK; step_data_rd = 1'b1; end
         default: begin step_cmd = CMD_STOP; step_last = 1'b1; end
      endcase
      if (nack_stop) begin
         step_cmd       = CMD_STOP;
         step_check_ack = 1'b0;
         step_data_rd   = 1'b0;
         step_last      = 1'b1;
      end
   end

   assign ack_bad = step_check_ack && (ri_to_cpu[5] != SACK_OK);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:     if (cmd_valid) state_nx = ISSUE_S;
         ISSUE_D:  state_nx = ISSUE_S;
         ISSUE_S:  state_nx = WAIT_RDY;
         WAIT_RDY: begin
            if (ri_int)         state_nx = STAT_RD;
            else if (wd_expire) state_nx = DONE;
         end
         STAT_RD:  state_nx = STAT_WAIT;
         STAT_WAIT: begin
            if (wait_cnt) begin
               if (ack_bad)                      state_nx = ISSUE_S;
               else if (step_data_rd)            state_nx = DATA_RD;
               else if (step_last)               state_nx = DONE;
               else if (has_byte(step_next, rd_q)) state_nx = ISSUE_D;
               else                              state_nx = ISSUE_S;
            end
         end
         DATA_RD:  state_nx = DATA_WAIT;
         DATA_WAIT: begin
            if (wait_cnt) state_nx = has_byte(step_next, rd_q) ? ISSUE_D : ISSUE_S;
         end
         DONE:     state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_comb begin
      ri_a        = 1'b0;
      ri_ce       = 1'b0;
      ri_wren     = 1'b0;
      ri_ren      = 1'b0;
      ri_from_cpu = 8'h00;
      case (state)
         ISSUE_D: begin ri_ce = 1'b1; ri_wren = 1'b1; ri_from_cpu = step_byte; end
         ISSUE_S: begin ri_a = 1'b1; ri_ce = 1'b1; ri_wren = 1'b1; ri_from_cpu = step_cmd; end
         STAT_RD: begin ri_a = 1'b1; ri_ce = 1'b1; ri_ren = 1'b1; end
         DATA_RD: begin ri_ce = 1'b1; ri_ren = 1'b1; end
         default: ;
      endcase
   end

   assign cmd_ready   = (state == IDLE);
   assign busy        = ~cmd_ready;
   assign rsp_valid   = (state == DONE);
   assign rsp_nack    = (state == DONE) && nack_stop && !tmo_q;
   assign rsp_timeout = (state == DONE) && tmo_q;

   // Step/latency bookkeeping; wait_cnt marks the second cycle after a read strobe.
   always_ff @(posedge clk) begin
      if (reset) begin
         step      <= 3'd0;
         wait_cnt  <= 1'b0;
         nack_stop <= 1'b0;
      end else begin
         wait_cnt <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  step      <= 3'd0;
                  nack_stop <= 1'b0;
               end
            end
            STAT_WAIT: begin
               wait_cnt <= ~wait_cnt;
               if (wait_cnt) begin
                  if (ack_bad)                         nack_stop <= 1'b1;
                  else if (!step_data_rd && !step_last) step <= step_next;
               end
            end
            DATA_WAIT: begin
               wait_cnt <= ~wait_cnt;
               if (wait_cnt) step <= step_next;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         rd_q    <= cmd_rd;
         dev_q   <= cmd_dev;
         addr_q  <= cmd_addr;
         wdata_q <= cmd_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)                                rsp_rdata <= 8'h00;
      else if (accept)                          rsp_rdata <= 8'h00;
      else if (state == DATA_WAIT && wait_cnt)  rsp_rdata <= ri_to_cpu;
   end

`ifdef I2C_SEQ_TIMEOUT_EN
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] wd_cnt;

   // Counter is zero on the first WAIT_RDY cycle; expiry aborts without a STOP.
   always_ff @(posedge clk) begin
      if (state != WAIT_RDY) wd_cnt <= 16'd0;
      else                   wd_cnt <= wd_cnt + 16'd1;
   end

   assign wd_expire = (state == WAIT_RDY) && !ri_int && (wd_cnt == WD_LAST);

   always_ff @(posedge clk) begin
      if (reset)          tmo_q <= 1'b0;
      else if (accept)    tmo_q <= 1'b0;
      else if (wd_expire) tmo_q <= 1'b1;
   end
`else
   assign wd_expire = 1'b0;
   assign tmo_q     = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_eeprom_seq.sv
// Directed bench for i2c_eeprom_seq: two instances (2-byte and 1-byte addressing)
// against a behavioural register-interface model that logs every bus write.
module tb_i2c_eeprom_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        cmd_valid [2];
   logic        cmd_rd;
   logic [6:0]  cmd_dev;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_wdata;
   logic        cmd_ready [2], rsp_valid [2], rsp_nack [2], rsp_timeout [2], busy [2];
   logic [7:0]  rsp_rdata [2];
   logic        ri_a [2], ri_ce [2], ri_wren [2], ri_ren [2], ri_int [2];
   logic [7:0]  ri_from_cpu [2], ri_to_cpu [2];

   // Register-interface model state
   logic        model_clr, int_en, tb_int;
   logic [3:0]  nack_at;
   logic [7:0]  rd_val;
   logic [7:0]  dlog [2][32];
   logic [7:0]  slog [2][32];
   logic [4:0]  dn [2], sn [2];
   logic [3:0]  wc [2];
   logic        pend [2], mint [2], rp1 [2], rp2 [2];
   logic [2:0]  cd [2];
   logic [7:0]  v1 [2], v2 [2];
   int          perr [2], rspn [2], cecnt [2];

   int          checks = 0;
   int          errors = 0;
   logic        r_nack, r_tmo;
   logic [7:0]  r_rdata;
   logic [7:0]  de [8], se [8];
   int          snap;

   i2c_eeprom_seq #(.ADDR_BYTES(2), .SACK_OK(1'b0), .TIMEOUT_CYCLES(100)) u_dut2 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_rd(cmd_rd), .cmd_dev(cmd_dev), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_nack(rsp_nack[0]),
      .rsp_timeout(rsp_timeout[0]), .busy(busy[0]), .ri_a(ri_a[0]), .ri_ce(ri_ce[0]),
      .ri_wren(ri_wren[0]), .ri_ren(ri_ren[0]), .ri_from_cpu(ri_from_cpu[0]),
      .ri_to_cpu(ri_to_cpu[0]), .ri_int(ri_int[0]));

   i2c_eeprom_seq #(.ADDR_BYTES(1), .SACK_OK(1'b0), .TIMEOUT_CYCLES(100)) u_dut1 (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_rd(cmd_rd), .cmd_dev(cmd_dev), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_nack(rsp_nack[1]),
      .rsp_timeout(rsp_timeout[1]), .busy(busy[1]), .ri_a(ri_a[1]), .ri_ce(ri_ce[1]),
      .ri_wren(ri_wren[1]), .ri_ren(ri_ren[1]), .ri_from_cpu(ri_from_cpu[1]),
      .ri_to_cpu(ri_to_cpu[1]), .ri_int(ri_int[1]));

   assign ri_to_cpu[0] = v2[0];
   assign ri_to_cpu[1] = v2[1];
   assign ri_int[0]    = mint[0] | tb_int;
   assign ri_int[1]    = mint[1] | tb_int;

   // Model: ri_int a few cycles after each status write, read data 2 cycles after ce&ren,
   // status bit 5 set after the nack_at-th WRITE command, 0xEE on the bus otherwise.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (model_clr) begin
            dn[i] <= '0; sn[i] <= '0; wc[i] <= '0; pend[i] <= 1'b0; cd[i] <= '0;
            mint[i] <= 1'b0; rp1[i] <= 1'b0; rp2[i] <= 1'b0; v1[i] <= 8'hEE; v2[i] <= 8'hEE;
            perr[i] <= 0; rspn[i] <= 0; cecnt[i] <= 0;
         end else begin
            if (ri_ce[i] && ri_wren[i] && !ri_a[i]) begin
               dlog[i][dn[i]] <= ri_from_cpu[i];
               dn[i] <= dn[i] + 5'd1;
            end
            if (ri_ce[i] && ri_wren[i] && ri_a[i]) begin
               slog[i][sn[i]] <= ri_from_cpu[i];
               sn[i] <= sn[i] + 5'd1;
               cd[i] <= 3'd3;
               if (ri_from_cpu[i] == 8'h08) begin
                  wc[i]   <= wc[i] + 4'd1;
                  pend[i] <= ((wc[i] + 4'd1) == nack_at);
               end else begin
                  pend[i] <= 1'b0;
               end
            end else if (cd[i] != 3'd0) begin
               cd[i] <= cd[i] - 3'd1;
            end
            mint[i] <= int_en && (cd[i] == 3'd1);
            rp1[i]  <= ri_ce[i] && ri_ren[i];
            rp2[i]  <= rp1[i];
            if (ri_ce[i] && ri_ren[i]) v1[i] <= ri_a[i] ? (pend[i] ? 8'h20 : 8'h00) : rd_val;
            else                       v1[i] <= 8'hEE;
            v2[i] <= v1[i];
            if (ri_ce[i]) cecnt[i] <= cecnt[i] + 1;
            if (ri_ce[i] && ((ri_wren[i] == ri_ren[i]) || rp1[i] || rp2[i])) perr[i] <= perr[i] + 1;
            if (rsp_valid[i]) rspn[i] <= rspn[i] + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      @(negedge clk); model_clr = 1'b1;
      @(negedge clk); model_clr = 1'b0;
   endtask

   task automatic run_cmd(input int k, input logic rd, input logic [6:0] dev,
                          input logic [15:0] addr, input logic [7:0] wd);
      @(negedge clk);
      cmd_rd = rd; cmd_dev = dev; cmd_addr = addr; cmd_wdata = wd;
      cmd_valid[k] = 1'b1;
      @(negedge clk);
      cmd_valid[k] = 1'b0;
   endtask

   task automatic wait_rsp(input int k, input string t);
      bit got = 1'b0;
      for (int c = 0; c < 600 && !got; c++) begin
         @(negedge clk);
         if (rsp_valid[k]) begin
            got = 1'b1; r_nack = rsp_nack[k]; r_tmo = rsp_timeout[k]; r_rdata = rsp_rdata[k];
         end
      end
      chk({t, "_rsp_seen"}, 32'(got), 1);
      @(negedge clk);
      chk({t, "_rsp_one_cycle"}, 32'(rsp_valid[k]), 0);
      chk({t, "_ready_after"}, 32'(cmd_ready[k]), 1);
      chk({t, "_timeout"}, 32'(r_tmo), 0);
   endtask

   task automatic chk_logs(input int k, input string t, input int dc, input int sc);
      repeat (3) @(negedge clk);
      chk({t, "_dwr_count"}, 32'(dn[k]), dc);
      for (int j = 0; j < dc; j++) chk($sformatf("%s_dwr%0d", t, j), 32'(dlog[k][j]), 32'(de[j]));
      chk({t, "_swr_count"}, 32'(sn[k]), sc);
      for (int j = 0; j < sc; j++) chk($sformatf("%s_swr%0d", t, j), 32'(slog[k][j]), 32'(se[j]));
      chk({t, "_rsp_pulses"}, 32'(rspn[k]), 1);
      chk({t, "_bus_protocol"}, 32'(perr[k]), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; cmd_valid[0] = 1'b0; cmd_valid[1] = 1'b0;
      cmd_rd = 1'b0; cmd_dev = '0; cmd_addr = '0; cmd_wdata = '0;
      model_clr = 1'b1; int_en = 1'b1; tb_int = 1'b0; nack_at = '0; rd_val = '0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_ready", 32'(cmd_ready[0]), 1);
      chk("rst_busy", 32'(busy[0]), 0);
      chk("rst_strobes", {28'd0, ri_a[0], ri_ce[0], ri_wren[0], ri_ren[0]}, 0);
      chk("rst_from_cpu", 32'(ri_from_cpu[0]), 0);
      chk("rst_rsp", {29'd0, rsp_valid[0], rsp_nack[0], rsp_timeout[0]}, 0);
      chk("rst_rdata", 32'(rsp_rdata[0]), 0);
      reset = 1'b0; model_clr = 1'b0;

      // Byte write; a second request while busy must be ignored and fields stay latched
      model_reset();
      @(negedge clk);
      cmd_rd = 1'b0; cmd_dev = 7'h50; cmd_addr = 16'h1234; cmd_wdata = 8'hA5; cmd_valid[0] = 1'b1;
      chk("wr_ready_idle", 32'(cmd_ready[0]), 1);
      @(negedge clk);
      chk("wr_busy", 32'(busy[0]), 1);
      cmd_rd = 1'b1; cmd_dev = 7'h11; cmd_addr = 16'hFFFF; cmd_wdata = 8'h00;
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      wait_rsp(0, "wr");
      chk("wr_nack", 32'(r_nack), 0);
      de = '{8'hA0, 8'h12, 8'h34, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
      se = '{8'h01, 8'h08, 8'h08, 8'h08, 8'h08, 8'h02, 8'h00, 8'h00};
      chk_logs(0, "wr", 4, 6);

      // Byte read with repeated START
      model_reset();
      rd_val = 8'h3C;
      run_cmd(0, 1'b1, 7'h50, 16'h0010, 8'h00);
      wait_rsp(0, "rd");
      chk("rd_nack", 32'(r_nack), 0);
      chk("rd_rdata", 32'(r_rdata), 32'h3C);
      de = '{8'hA0, 8'h00, 8'h10, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00};
      se = '{8'h01, 8'h08, 8'h08, 8'h08, 8'h01, 8'h08, 8'h14, 8'h02};
      chk_logs(0, "rd", 4, 8);
      repeat (5) @(negedge clk);
      chk("rd_rdata_held", 32'(rsp_rdata[0]), 32'h3C);

      // Slave NACK on the second address byte
      model_reset();
      nack_at = 4'd3;
      run_cmd(0, 1'b0, 7'h50, 16'h1234, 8'hA5);
      wait_rsp(0, "nk");
      chk("nk_nack", 32'(r_nack), 1);
      de = '{8'hA0, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      se = '{8'h01, 8'h08, 8'h08, 8'h08, 8'h02, 8'h00, 8'h00, 8'h00};
      chk_logs(0, "nk", 3, 5);
      nack_at = 4'd0;

      // One address byte: write
      model_reset();
      run_cmd(1, 1'b0, 7'h50, 16'h0077, 8'h5A);
      wait_rsp(1, "a1wr");
      chk("a1wr_nack", 32'(r_nack), 0);
      de = '{8'hA0, 8'h77, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      se = '{8'h01, 8'h08, 8'h08, 8'h08, 8'h02, 8'h00, 8'h00, 8'h00};
      chk_logs(1, "a1wr", 3, 5);

      // One address byte: read
      model_reset();
      rd_val = 8'h96;
      run_cmd(1, 1'b1, 7'h2B, 16'hABC4, 8'h00);
      wait_rsp(1, "a1rd");
      chk("a1rd_rdata", 32'(r_rdata), 32'h96);
      de = '{8'h56, 8'hC4, 8'h57, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      se = '{8'h01, 8'h08, 8'h08, 8'h01, 8'h08, 8'h14, 8'h02, 8'h00};
      chk_logs(1, "a1rd", 3, 7);

      // NACK on the control byte of a read
      model_reset();
      nack_at = 4'd1;
      run_cmd(1, 1'b1, 7'h2B, 16'h0001, 8'h00);
      wait_rsp(1, "devnk");
      chk("devnk_nack", 32'(r_nack), 1);
      de = '{8'h56, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      se = '{8'h01, 8'h08, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      chk_logs(1, "devnk", 1, 3);
      nack_at = 4'd0;

      // Stray ri_int while idle must not start any bus access
      model_reset();
      snap = cecnt[0] + cecnt[1];
      @(negedge clk); tb_int = 1'b1;
      @(negedge clk); tb_int = 1'b0;
      repeat (5) @(negedge clk);
      chk("stray_int_no_access", 32'(cecnt[0] + cecnt[1]), 32'(snap));
      chk("stray_int_ready", 32'(cmd_ready[0]), 1);

      // Reset while parked in WAIT_RDY
      model_reset();
      int_en = 1'b0;
      run_cmd(0, 1'b0, 7'h50, 16'h1234, 8'hA5);
      repeat (6) @(negedge clk);
      chk("rstw_busy", 32'(busy[0]), 1);
      reset = 1'b1;
      @(negedge clk);
      chk("rstw_strobes", {28'd0, ri_a[0], ri_ce[0], ri_wren[0], ri_ren[0]}, 0);
      chk("rstw_ready", 32'(cmd_ready[0]), 1);
      chk("rstw_rsp_valid", 32'(rsp_valid[0]), 0);
      reset = 1'b0; int_en = 1'b1;
      repeat (5) @(negedge clk);
      chk("rstw_no_rsp", 32'(rspn[0]), 0);
      chk("rstw_no_stop", 32'(sn[0]), 1);

      // Recovery after reset with boundary field values
      model_reset();
      run_cmd(0, 1'b0, 7'h7F, 16'hFF00, 8'h00);
      wait_rsp(0, "rec");
      chk("rec_nack", 32'(r_nack), 0);
      de = '{8'hFE, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      se = '{8'h01, 8'h08, 8'h08, 8'h08, 8'h08, 8'h02, 8'h00, 8'h00};
      chk_logs(0, "rec", 4, 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
